coh_cache_ctrl: RTL and testbench

Per-CPU snooping coherence controller implementing the cache side of the MSI bus protocol: it issues read_miss/write_miss/invalidate requests, owns the tag/state array, and answers bus snoops. One instance sits inside each cpu, between the CPU memory stage and the shared bus arbiter. Line data storage is outside this block; it only tracks tags and MSI state and signals when data must be supplied or written back.

---
 rtl/coh_cache_if.sv | 37 +++
 rtl/coh_cache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_coh_cache_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/coh_cache_if.sv
// CPU-side and snooping-bus signals of one MSI cache controller.
// The controller takes the master modport; the CPU/bus side takes slave.
interface coh_cache_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_stall;
  logic              cpu_done;
  logic              read_miss;
  logic              write_miss;
  logic              invalidate;
  logic [ADDR_W-1:0] BICO;
  logic [1:0]        block_state;
  logic              grant;
  logic [ADDR_W-1:0] BOCI;
  logic              cpu_search;
  logic              cpu_datasel;
  logic              cpu_search_found;
  logic              invalidate_from_other_cpu;
  logic              wback;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, grant, BOCI, cpu_search, cpu_datasel,
           invalidate_from_other_cpu,
    output cpu_stall, cpu_done, read_miss, write_miss, invalidate, BICO,
           block_state, cpu_search_found, wback
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, grant, BOCI, cpu_search, cpu_datasel,
           invalidate_from_other_cpu,
    input  cpu_stall, cpu_done, read_miss, write_miss, invalidate, BICO,
           block_state, cpu_search_found, wback
  );
endinterface

// File: rtl/coh_cache_ctrl.sv
// Direct-mapped MSI snooping controller: tag/state array, miss/upgrade
// requests toward the bus arbiter, and snoop/invalidate responses.
//   state | meaning
//   IDLE  | no bus request outstanding; hits complete here
//   MISS  | read_miss or write_miss held until grant
//   UPG   | invalidate (S->M upgrade) held until grant
module coh_cache_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  coh_cache_if.master bus
);
  localparam int TAG_W  = ADDR_W - INDEX_W;
  localparam int NLINES = 1 << INDEX_W;
  localparam logic [1:0] LS_I = 2'b00, LS_S = 2'b01, LS_M = 2'b10;

  typedef enum logic [1:0] {IDLE, MISS, UPG} fsm_t;

  fsm_t              state_q, state_d;
  logic [1:0]        st_q  [NLINES];
  logic [TAG_W-1:0]  tag_q [NLINES];

  logic              done_q, rm_q, wm_q, inv_q, found_q, wback_q;
  logic              done_d, rm_d, wm_d, inv_d, wback_d;
  logic [ADDR_W-1:0] bico_q, bico_d;
  logic [1:0]        bs_q, bs_d;
  logic              fill, upg;

  logic [INDEX_W-1:0] cidx, sidx, bidx;
  logic [TAG_W-1:0]   ctag, stag, btag;
  logic               hit, hit_ok, smatch, evict, snoop_wb;

  assign cidx = bus.cpu_addr[INDEX_W-1:0];
  assign ctag = bus.cpu_addr[ADDR_W-1:INDEX_W];
  assign sidx = bus.BOCI[INDEX_W-1:0];
  assign stag = bus.BOCI[ADDR_W-1:INDEX_W];
  assign bidx = bico_q[INDEX_W-1:0];
  assign btag = bico_q[ADDR_W-1:INDEX_W];

  assign hit    = (st_q[cidx] != LS_I) && (tag_q[cidx] == ctag);
  assign hit_ok = hit && (!bus.cpu_we || st_q[cidx] == LS_M);
  assign smatch = (st_q[sidx] != LS_I) && (tag_q[sidx] == stag);

  // Own fill/upgrade at the same index overrides a coincident snoop.
  assign evict    = fill && (st_q[bidx] == LS_M) && (tag_q[bidx] != btag);
  assign snoop_wb = smatch && (st_q[sidx] == LS_M)
                    && ((bus.cpu_search && bus.cpu_datasel) || bus.invalidate_from_other_cpu)
                    && !((fill || upg) && sidx == bidx);
  assign wback_d  = evict || snoop_wb;

  assign bus.cpu_stall        = (state_q != IDLE) || (bus.cpu_req && !done_q && !hit_ok);
  assign bus.cpu_done         = done_q;
  assign bus.read_miss        = rm_q;
  assign bus.write_miss       = wm_q;
  assign bus.invalidate       = inv_q;
  assign bus.BICO             = bico_q;
  assign bus.block_state      = bs_q;
  assign bus.cpu_search_found = found_q;
  assign bus.wback            = wback_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rm_d    = rm_q;
    wm_d    = wm_q;
    inv_d   = inv_q;
    bico_d  = bico_q;
    bs_d    = bs_q;
    fill    = 1'b0;
    upg     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req && !done_q) begin
          if (hit_ok) begin
            done_d = 1'b1;
          end else if (hit) begin
            state_d = UPG;
            inv_d   = 1'b1;
            bico_d  = bus.cpu_addr;
            bs_d    = LS_S;
          end else begin
            state_d = MISS;
            rm_d    = !bus.cpu_we;
            wm_d    = bus.cpu_we;
            bico_d  = bus.cpu_addr;
            bs_d    = LS_I;
          end
        end
      end
      MISS: begin
        if (bus.grant) begin
          fill    = 1'b1;
          rm_d    = 1'b0;
          wm_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      UPG: begin
        if (bus.grant) begin
          upg     = 1'b1;
          inv_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.invalidate_from_other_cpu && smatch && sidx == bidx) begin
          // Lost the line while waiting: fall back to a full write miss.
          inv_d   = 1'b0;
          wm_d    = 1'b1;
          bs_d    = LS_I;
          state_d = MISS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rm_q    <= 1'b0;
      wm_q    <= 1'b0;
      inv_q   <= 1'b0;
      bico_q  <= '0;
      bs_q    <= LS_I;
      found_q <= 1'b0;
      wback_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rm_q    <= rm_d;
      wm_q    <= wm_d;
      inv_q   <= inv_d;
      bico_q  <= bico_d;
      bs_q    <= bs_d;
      found_q <= bus.cpu_search && smatch;
      wback_q <= wback_d;
    end
  end

  // Later assignments win, so fill/upgrade take priority over snoops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLINES; i++) begin
        st_q[i]  <= LS_I;
        tag_q[i] <= '0;
      end
    end else begin
      if (bus.cpu_search && bus.cpu_datasel && smatch && st_q[sidx] == LS_M)
        st_q[sidx] <= LS_S;
      if (bus.invalidate_from_other_cpu && smatch)
        st_q[sidx] <= LS_I;
      if (fill) begin
        st_q[bidx]  <= wm_q ? LS_M : LS_S;
        tag_q[bidx] <= btag;
      end
      if (upg)
        st_q[bidx] <= LS_M;
    end
  end
endmodule

// File: tb/tb_coh_cache_ctrl.sv
// Directed bench for coh_cache_ctrl: miss/hit/upgrade/eviction, snoops,
// upgrade loss to a remote invalidate, grant-vs-snoop priority and reset.
module tb_coh_cache_ctrl;
  logic clk, rst;
  int n_cmp, n_err;

  coh_cache_if #(.ADDR_W(11)) bus ();

  coh_cache_ctrl #(.ADDR_W(11), .INDEX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.grant = 0;
    bus.BOCI = '0; bus.cpu_search = 0; bus.cpu_datasel = 0;
    bus.invalidate_from_other_cpu = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    n_cmp++; if (bus.read_miss !== 1'b0) begin n_err++; $display("FAIL rst_read_miss got %b exp 0", bus.read_miss); end
    n_cmp++; if (bus.write_miss !== 1'b0) begin n_err++; $display("FAIL rst_write_miss got %b exp 0", bus.write_miss); end
    n_cmp++; if (bus.invalidate !== 1'b0) begin n_err++; $display("FAIL rst_invalidate got %b exp 0", bus.invalidate); end
    n_cmp++; if (bus.cpu_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", bus.cpu_done); end
    n_cmp++; if (bus.BICO !== 11'h000) begin n_err++; $display("FAIL rst_bico got %h exp 000", bus.BICO); end
    n_cmp++; if (bus.block_state !== 2'b00) begin n_err++; $display("FAIL rst_block_state got %b exp 00", bus.block_state); end
    n_cmp++; if (bus.wback !== 1'b0) begin n_err++; $display("FAIL rst_wback got %b exp 0", bus.wback); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", bus.cpu_stall); end
    rst = 0; tick();
  endtask

  task automatic test_empty_probe();
    bus.cpu_search = 1; bus.BOCI = 11'h123; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b0) begin n_err++; $display("FAIL empty_probe got %b exp 0", bus.cpu_search_found); end
    bus.cpu_search = 0; tick();
  endtask

  task automatic test_read_miss_hit();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'h005; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL rmiss_stall_t0 got %b exp 1", bus.cpu_stall); end
    tick();
    n_cmp++; if (bus.read_miss !== 1'b1) begin n_err++; $display("FAIL rmiss_t1 got %b exp 1", bus.read_miss); end
    n_cmp++; if (bus.write_miss !== 1'b0) begin n_err++; $display("FAIL rmiss_wm_t1 got %b exp 0", bus.write_miss); end
    n_cmp++; if (bus.BICO !== 11'h005) begin n_err++; $display("FAIL rmiss_bico got %h exp 005", bus.BICO); end
    n_cmp++; if (bus.block_state !== 2'b00) begin n_err++; $display("FAIL rmiss_bs got %b exp 00", bus.block_state); end
    tick();
    n_cmp++; if (bus.read_miss !== 1'b1) begin n_err++; $display("FAIL rmiss_held_t2 got %b exp 1", bus.read_miss); end
    n_cmp++; if (bus.cpu_done !== 1'b0) begin n_err++; $display("FAIL rmiss_done_t2 got %b exp 0", bus.cpu_done); end
    bus.grant = 1; tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL rmiss_done_t3 got %b exp 1", bus.cpu_done); end
    n_cmp++; if (bus.read_miss !== 1'b0) begin n_err++; $display("FAIL rmiss_clear_t3 got %b exp 0", bus.read_miss); end
    bus.cpu_req = 0; bus.grant = 0; tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'h005; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rhit_stall got %b exp 0", bus.cpu_stall); end
    tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL rhit_done got %b exp 1", bus.cpu_done); end
    n_cmp++; if (bus.read_miss !== 1'b0) begin n_err++; $display("FAIL rhit_no_req got %b exp 0", bus.read_miss); end
    bus.cpu_req = 0; tick();
  endtask

  task automatic test_upgrade_snoop();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h005; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL upg_stall got %b exp 1", bus.cpu_stall); end
    tick();
    n_cmp++; if (bus.invalidate !== 1'b1) begin n_err++; $display("FAIL upg_inv got %b exp 1", bus.invalidate); end
    n_cmp++; if (bus.block_state !== 2'b01) begin n_err++; $display("FAIL upg_bs got %b exp 01", bus.block_state); end
    n_cmp++; if (bus.write_miss !== 1'b0) begin n_err++; $display("FAIL upg_wm got %b exp 0", bus.write_miss); end
    bus.grant = 1; tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL upg_done got %b exp 1", bus.cpu_done); end
    n_cmp++; if (bus.invalidate !== 1'b0) begin n_err++; $display("FAIL upg_inv_clear got %b exp 0", bus.invalidate); end
    bus.cpu_req = 0; bus.grant = 0; tick();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h005; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL whit_m_stall got %b exp 0", bus.cpu_stall); end
    tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL whit_m_done got %b exp 1", bus.cpu_done); end
    bus.cpu_req = 0; bus.cpu_search = 1; bus.cpu_datasel = 1; bus.BOCI = 11'h005; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b1) begin n_err++; $display("FAIL snoop_found got %b exp 1", bus.cpu_search_found); end
    n_cmp++; if (bus.wback !== 1'b1) begin n_err++; $display("FAIL snoop_wback got %b exp 1", bus.wback); end
    bus.cpu_search = 0; bus.cpu_datasel = 0; tick();
    n_cmp++; if (bus.wback !== 1'b0) begin n_err++; $display("FAIL snoop_wback_pulse got %b exp 0", bus.wback); end
  endtask

  task automatic test_upg_killed();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h005; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL kill_line_is_s got %b exp 1", bus.cpu_stall); end
    tick();
    n_cmp++; if (bus.invalidate !== 1'b1) begin n_err++; $display("FAIL kill_inv_up got %b exp 1", bus.invalidate); end
    bus.invalidate_from_other_cpu = 1; bus.BOCI = 11'h005; tick();
    n_cmp++; if (bus.invalidate !== 1'b0) begin n_err++; $display("FAIL kill_inv_drop got %b exp 0", bus.invalidate); end
    n_cmp++; if (bus.write_miss !== 1'b1) begin n_err++; $display("FAIL kill_wm got %b exp 1", bus.write_miss); end
    n_cmp++; if (bus.block_state !== 2'b00) begin n_err++; $display("FAIL kill_bs got %b exp 00", bus.block_state); end
    n_cmp++; if (bus.wback !== 1'b0) begin n_err++; $display("FAIL kill_wback got %b exp 0", bus.wback); end
    bus.invalidate_from_other_cpu = 0; bus.grant = 1; tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL kill_done got %b exp 1", bus.cpu_done); end
    n_cmp++; if (bus.write_miss !== 1'b0) begin n_err++; $display("FAIL kill_wm_clear got %b exp 0", bus.write_miss); end
    n_cmp++; if (bus.wback !== 1'b0) begin n_err++; $display("FAIL kill_fill_wback got %b exp 0", bus.wback); end
    bus.cpu_req = 0; bus.grant = 0; tick();
  endtask

  task automatic test_evict();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h00D; tick();
    n_cmp++; if (bus.write_miss !== 1'b1) begin n_err++; $display("FAIL evict_wm got %b exp 1", bus.write_miss); end
    n_cmp++; if (bus.BICO !== 11'h00D) begin n_err++; $display("FAIL evict_bico got %h exp 00d", bus.BICO); end
    bus.grant = 1; tick();
    n_cmp++; if (bus.wback !== 1'b1) begin n_err++; $display("FAIL evict_wback got %b exp 1", bus.wback); end
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL evict_done got %b exp 1", bus.cpu_done); end
    bus.cpu_req = 0; bus.grant = 0; bus.cpu_search = 1; bus.BOCI = 11'h005; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b0) begin n_err++; $display("FAIL evict_old_probe got %b exp 0", bus.cpu_search_found); end
    bus.BOCI = 11'h00D; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b1) begin n_err++; $display("FAIL evict_new_probe got %b exp 1", bus.cpu_search_found); end
    bus.cpu_search = 0; bus.invalidate_from_other_cpu = 1; tick();
    n_cmp++; if (bus.wback !== 1'b1) begin n_err++; $display("FAIL inv_m_wback got %b exp 1", bus.wback); end
    bus.invalidate_from_other_cpu = 0; bus.cpu_search = 1; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b0) begin n_err++; $display("FAIL inv_m_gone got %b exp 0", bus.cpu_search_found); end
    bus.cpu_search = 0; tick();
  endtask

  task automatic test_grant_wins();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'h123; tick();
    bus.grant = 1; tick();
    bus.cpu_req = 0; bus.grant = 0; tick();
    bus.cpu_req = 1; bus.cpu_we = 1; tick();
    n_cmp++; if (bus.invalidate !== 1'b1) begin n_err++; $display("FAIL gw_inv got %b exp 1", bus.invalidate); end
    bus.grant = 1; bus.invalidate_from_other_cpu = 1; bus.BOCI = 11'h123; tick();
    n_cmp++; if (bus.cpu_done !== 1'b1) begin n_err++; $display("FAIL gw_done got %b exp 1", bus.cpu_done); end
    n_cmp++; if (bus.write_miss !== 1'b0) begin n_err++; $display("FAIL gw_no_wm got %b exp 0", bus.write_miss); end
    bus.cpu_req = 0; bus.grant = 0; bus.invalidate_from_other_cpu = 0; tick();
    bus.cpu_search = 1; bus.cpu_datasel = 1; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b1) begin n_err++; $display("FAIL gw_found got %b exp 1", bus.cpu_search_found); end
    n_cmp++; if (bus.wback !== 1'b1) begin n_err++; $display("FAIL gw_line_m got %b exp 1", bus.wback); end
    bus.cpu_search = 0; bus.cpu_datasel = 0; tick();
  endtask

  task automatic test_reset_mid_request();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 11'h0AA; tick();
    n_cmp++; if (bus.read_miss !== 1'b1) begin n_err++; $display("FAIL rmid_rm got %b exp 1", bus.read_miss); end
    rst = 1; tick();
    n_cmp++; if (bus.read_miss !== 1'b0) begin n_err++; $display("FAIL rmid_rm_clear got %b exp 0", bus.read_miss); end
    n_cmp++; if (bus.BICO !== 11'h000) begin n_err++; $display("FAIL rmid_bico got %h exp 000", bus.BICO); end
    n_cmp++; if (bus.cpu_done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b exp 0", bus.cpu_done); end
    rst = 0; bus.cpu_req = 0; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got %b exp 0", bus.cpu_stall); end
    bus.cpu_search = 1; bus.BOCI = 11'h123; tick();
    n_cmp++; if (bus.cpu_search_found !== 1'b0) begin n_err++; $display("FAIL rmid_array_clear got %b exp 0", bus.cpu_search_found); end
    bus.cpu_search = 0; tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_empty_probe();
    test_read_miss_hit();
    test_upgrade_snoop();
    test_upg_killed();
    test_evict();
    test_grant_wins();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
